// File: rtl/inm_gen_pkg.sv
// Shared opcode constants and immediate format encoding for the
// immediate generator pipeline.
package inm_gen_pkg;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_t;

endpackage

// File: rtl/inm_gen_if.sv
// Decode-side and execute-side handshake bundle of the
// immediate generator pipeline.
interface inm_gen_if
  import inm_gen_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_inm;
  logic [XLEN-1:0] out_pc;
  fmt_t            out_fmt;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_inm, out_pc,
    input  out_fmt, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_inm, out_pc,
    output out_fmt, out_illegal
  );
endinterface

// File: rtl/inm_gen_core.sv
// Combinational RV32I/RV64I immediate decoder.
// Define INM_GEN_CSR_EN to decode SYSTEM/CSR immediates.
module inm_gen_core
  import inm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] inm,
  output fmt_t            fmt,
  output logic            illegal
);
  localparam int SH = $clog2(XLEN);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       sh_op;

  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign sh_op = (opc == OPIMM) &&
                 (f3 == 3'b001 || f3 == 3'b101);

  function automatic logic [XLEN-1:0] sx(
    input logic [31:0] v
  );
    sx = {{(XLEN-31){v[31]}}, v[30:0]};
  endfunction

  always_comb begin
    inm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    unique case (1'b1)
      sh_op: begin
        inm = {{(XLEN-SH){1'b0}}, inst[20 +: SH]};
        fmt = FMT_I;
      end
      (opc == LOAD) || (opc == JALR) ||
      ((opc == OPIMM) && !sh_op): begin
        inm = sx({{20{inst[31]}}, inst[31:20]});
        fmt = FMT_I;
      end
      opc == STORE: begin
        inm = sx({{20{inst[31]}}, inst[31:25],
                  inst[11:7]});
        fmt = FMT_S;
      end
      opc == BRANCH: begin
        inm = sx({{19{inst[31]}}, inst[31], inst[7],
                  inst[30:25], inst[11:8], 1'b0});
        fmt = FMT_B;
      end
      (opc == LUI) || (opc == AUIPC): begin
        inm = sx({inst[31:12], 12'b0});
        fmt = FMT_U;
      end
      opc == JAL: begin
        inm = sx({{11{inst[31]}}, inst[31], inst[19:12],
                  inst[20], inst[30:21], 1'b0});
        fmt = FMT_J;
      end
      opc == OP: begin
        fmt = FMT_NONE;
      end
`ifdef INM_GEN_CSR_EN
      opc == SYSTEM: begin
        if (f3[2]) begin
          inm = {{(XLEN-5){1'b0}}, inst[19:15]};
          fmt = FMT_Z;
        end else begin
          inm = sx({{20{inst[31]}}, inst[31:20]});
          fmt = FMT_I;
        end
      end
`endif
      default: begin
        illegal = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/inm_gen_pipe.sv
// Immediate decoder feeding a DEPTH-entry elastic FIFO that
// carries {inm, pc, fmt, illegal} toward execute.
module inm_gen_pipe
  import inm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input logic     CLK,
  input logic     RST,
  inm_gen_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] dec_inm;
  fmt_t            dec_fmt;
  logic            dec_ill;

  inm_gen_core #(.XLEN(XLEN)) u_core (
    .inst    (bus.in_inst),
    .inm     (dec_inm),
    .fmt     (dec_fmt),
    .illegal (dec_ill)
  );

  logic [XLEN-1:0] inm_q [DEPTH];
  logic [XLEN-1:0] pc_q  [DEPTH];
  fmt_t            fmt_q [DEPTH];
  logic            ill_q [DEPTH];

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  assign bus.in_ready  = !RST && (count < FULL);
  assign bus.out_valid = (count != '0);
  assign push = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop  = bus.out_valid && bus.out_ready;

  // Outputs read as zero when empty, so reset/flush need not clear storage.
  assign bus.out_inm     = bus.out_valid ? inm_q[rptr] : '0;
  assign bus.out_pc      = bus.out_valid ? pc_q[rptr]  : '0;
  assign bus.out_fmt     = bus.out_valid ? fmt_q[rptr] : FMT_NONE;
  assign bus.out_illegal = bus.out_valid && ill_q[rptr];

  always_ff @(posedge CLK) begin
    if (push) begin
      inm_q[wptr] <= dec_inm;
      pc_q[wptr]  <= bus.in_pc;
      fmt_q[wptr] <= dec_fmt;
      ill_q[wptr] <= dec_ill;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || bus.flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule
